exe_muldiv_unit: RTL
====================

Name: exe_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EXE stage, with architectural HI/LO registers.
- Consumes the latched ALU operands and the decoded mult/div operation from the ID/EXE boundary.
- Holds `busy` to the pipeline controller so that the ID/EXE enable is dropped until the result is in HI/LO.
- Serves mult, multu, div, divu, mthi, mtlo; mfhi/mflo read `hi_out`/`lo_out` directly.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  operation code (MD_OP_* from package)
- opr1  input  XLEN  rs operand (multiplicand / dividend / mthi-mtlo data)
- opr2  input  XLEN  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight operation (exception/redirect)
- busy  output  1  high while the state is not IDLE
- done  output  1  one-cycle pulse after HI/LO are updated by mult/div
- hi_out  output  XLEN  HI register
- lo_out  output  XLEN  LO register

Behaviour:
- Reset (async, `reset`=0):
  - State goes to IDLE.
  - `hi_out`, `lo_out`, `busy`, `done` and the iteration counter all become 0.
  - Reset mid-operation discards all work.
- States: IDLE, CALC, FIXUP.
- `busy` = (state != IDLE), decoded from the state register with no combinational path from `start`.
- IDLE, `start`=1 with op MTHI/MTLO:
  - HI (or LO) <= `opr1` at that edge.
  - State stays IDLE; `busy` stays 0; `done` is not pulsed.
- IDLE, `start`=1 with op MULT/MULTU/DIV/DIVU:
  - Latch |opr1| and |opr2| (signed ops) or the raw values (unsigned ops).
  - Latch the result sign (mult: sign1^sign2; quotient: sign1^sign2; remainder: sign1).
  - Clear the 64-bit accumulator and counter; go to CALC.
- CALC: one radix-2 step per cycle, 32 cycles (counter 0..31); after the step at counter=31, go to FIXUP.
  - Mult: shift-add step, multiplier LSB first.
  - Div: restoring shift-subtract step, quotient bit shifted into LO.
- FIXUP (one cycle):
  - Apply two's-complement negation per the latched signs.
  - Write HI/LO; go to IDLE.
  - Mult: HI = product[63:32], LO = product[31:0].
  - Div: LO = quotient, HI = remainder.
  - `done` is registered and is high in the cycle following the FIXUP edge.
- Latency: `start` accepted at edge E0 → HI/LO valid after edge E33; `busy` high for exactly 33 cycles.
- Divide by zero (any sign): LO = 0xFFFFFFFF, HI = `opr1` (original, unsigned view); full 33-cycle latency.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while busy: ignored; the controller must not issue it.
- `flush` in CALC/FIXUP: next state IDLE, HI/LO unchanged, no `done`.
- `flush` in IDLE has priority over `start` (the request is dropped).
- Simultaneous `flush` and the FIXUP edge: the flush wins and HI/LO are not written.
- Unknown op with `start`: ignored.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU in IDLE compute the 64-bit product with a single-cycle multiplier.
  - HI/LO are written at the accepting edge; state stays IDLE; `busy` is never asserted.
  - `done` pulses the next cycle.
  - DIV/DIVU are unchanged.
- Undefined: every mult/div takes the iterative 33-cycle path and no multiplier primitive is inferred.

Decomposition:
- Shared package `muldiv_pkg` holds:
  - op encodings: MD_OP_MULT=0, MD_OP_MULTU=1, MD_OP_DIV=2, MD_OP_DIVU=3, MD_OP_MTHI=4, MD_OP_MTLO=5;
  - state encoding: IDLE=0, CALC=1, FIXUP=2;
  - MD_ITERATIONS=32.
- One natural sub-module: `muldiv_step`, the combinational single radix-2 step (add-or-shift for mult, trial subtract for div), instantiated once in CALC.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; `done` pulses once; `busy` high exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 → LO=14, HI=2.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload via MTHI 0xAAAA0000 and MTLO 0x5555; start DIV, assert `flush` at cycle 10 → `busy` drops next cycle, HI=0xAAAA0000, LO=0x5555, no `done`.
- Drive async `reset` low at cycle 20 of a MULT → all outputs 0 immediately; a new MULTU 6×7 after release gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// =============================================================================
// Module  : muldiv_pkg
// Brief   : Shared op codes, FSM states and helpers for the EXE mul/div unit.
// Rev     : 1.0  initial release
// =============================================================================
package muldiv_pkg;

    localparam int MD_XLEN       = 32;
    localparam int MD_ITERATIONS = 32;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_t;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exe_muldiv_unit_step.sv
`default_nettype none
// =============================================================================
// Module  : muldiv_step
// Brief   : One combinational radix-2 step: shift-add multiply or restoring
//           trial-subtract divide on the 64-bit accumulator.
// Rev     : 1.0  initial release
// =============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_rem_new;
    logic            w_qbit;

    // Multiply: opa is the multiplicand, opb[0] the current multiplier bit.
    assign w_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (opb[0] ? opa : {XLEN{1'b0}})};

    // Divide: opa supplies dividend bits MSB first, opb is the divisor.
    // The partial remainder is always < divisor, so the shifted value fits XLEN+1
    // bits and a successful subtract leaves a result that fits XLEN bits.
    assign w_rem_shift = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    assign w_qbit      = (w_rem_shift >= {1'b0, opb});
    assign w_sub       = w_rem_shift[XLEN-1:0] - opb;
    assign w_rem_new   = w_qbit ? w_sub : w_rem_shift[XLEN-1:0];

    always_comb begin
        acc_next = acc;
        if (is_div) begin
            acc_next = {w_rem_new, acc[XLEN-2:0], w_qbit};
        end else begin
            acc_next = {w_sum, acc[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// =============================================================================
// Module  : exe_muldiv_unit
// Brief   : Iterative 32-step multiply/divide with architectural HI/LO.
//           Optional macro MULDIV_FAST_MULT_EN: single-cycle mult/multu.
// Rev     : 1.0  initial release
// =============================================================================
module exe_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int                 c_cnt_w = $clog2(MD_ITERATIONS);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MD_ITERATIONS - 1);

    md_state_t           r_state;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_done;
    logic [c_cnt_w-1:0]  r_count;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opa;
    logic [XLEN-1:0]     r_opb;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_signed;
    logic                w_div;
    logic                w_sign1;
    logic                w_sign2;
    logic [XLEN-1:0]     w_abs1;
    logic [XLEN-1:0]     w_abs2;
    logic                w_div0;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;

    assign w_signed = md_is_signed(op);
    assign w_div    = md_is_div(op);
    assign w_sign1  = w_signed & opr1[XLEN-1];
    assign w_sign2  = w_signed & opr2[XLEN-1];
    assign w_abs1   = w_sign1 ? (~opr1 + 1'b1) : opr1;
    assign w_abs2   = w_sign2 ? (~opr2 + 1'b1) : opr2;
    assign w_div0   = w_div & (opr2 == {XLEN{1'b0}});

`ifdef MULDIV_FAST_MULT_EN
    logic [2*XLEN-1:0] w_fast_mag;
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_fast_mag  = {{XLEN{1'b0}}, w_abs1} * {{XLEN{1'b0}}, w_abs2};
    assign w_fast_prod = (w_sign1 ^ w_sign2) ? (~w_fast_mag + 1'b1) : w_fast_mag;
`endif

    muldiv_step #(
        .XLEN     (XLEN)
    ) u_step (
        .is_div   (r_is_div),
        .acc      (r_acc),
        .opa      (r_opa),
        .opb      (r_opb),
        .acc_next (w_acc_next)
    );

    assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MD_OP_MTHI: r_hi <= opr1;
                            MD_OP_MTLO: r_lo <= opr1;
`ifdef MULDIV_FAST_MULT_EN
                            MD_OP_MULT, MD_OP_MULTU: begin
                                r_hi   <= w_fast_prod[2*XLEN-1:XLEN];
                                r_lo   <= w_fast_prod[XLEN-1:0];
                                r_done <= 1'b1;
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
`else
                            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
`endif
                                // Divide by zero runs on the raw dividend with no
                                // sign fixup, so HI ends up as opr1 and LO all ones.
                                r_is_div <= w_div;
                                r_opa    <= w_div0 ? opr1 : w_abs1;
                                r_opb    <= w_abs2;
                                r_neg_q  <= ~w_div0 & (w_sign1 ^ w_sign2);
                                r_neg_r  <= ~w_div0 & w_div & w_sign1;
                                r_acc    <= '0;
                                r_count  <= '0;
                                r_state  <= MD_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        r_state <= MD_IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + 1'b1;
                        if (r_is_div) begin
                            r_opa <= {r_opa[XLEN-2:0], 1'b0};
                        end else begin
                            r_opb <= {1'b0, r_opb[XLEN-1:1]};
                        end
                        if (r_count == c_last) begin
                            r_state <= MD_FIXUP;
                        end
                    end
                end
                MD_FIXUP: begin
                    r_state <= MD_IDLE;
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                            r_lo <= w_prod_fix[XLEN-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != MD_IDLE);
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
`default_nettype wire
